// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the instruction/data memory arbiter.
// MEM_ARB_ROUND_ROBIN_EN switches collision handling from fixed D priority to round robin.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_ST_IDLE = 2'd0,
    ARB_ST_BUSY = 2'd1,
    ARB_ST_RESP = 2'd2
  } arbState_e;

  typedef enum logic {
    ARB_OWN_I = 1'b0,
    ARB_OWN_D = 1'b1
  } arbOwner_e;

  // Bit position of the memory-timeout cause in the core halt vector
  localparam int HALT_MEMTO = 3;

  function automatic int wdWidth(input int timeout);
    return (timeout < 1) ? 1 : $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundles the fetch, data and memory-side handshakes of the arbiter.
// slave is the arbiter's own view; master is the view of the core and memory around it.
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic              i_ack;
  logic [DATA_W-1:0] i_rdata;
  logic              d_req;
  logic              d_rw;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_ack;
  logic [DATA_W-1:0] d_rdata;
  logic              m_stb;
  logic              m_rw;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_wdata;
  logic [DATA_W-1:0] m_rdata;
  logic              m_ack;
  logic              err;

  modport slave (
    input  i_req, i_addr, d_req, d_rw, d_addr, d_wdata, m_rdata, m_ack,
    output i_ack, i_rdata, d_ack, d_rdata, m_stb, m_rw, m_addr, m_wdata, err
  );

  modport master (
    output i_req, i_addr, d_req, d_rw, d_addr, d_wdata, m_rdata, m_ack,
    input  i_ack, i_rdata, d_ack, d_rdata, m_stb, m_rw, m_addr, m_wdata, err
  );

endinterface

// File: rtl/mem_arbiter_watchdog.sv
// Counts cycles while a memory transaction is outstanding and pulses expired_o
// on the TIMEOUT-th cycle without completion; TIMEOUT of 0 disables it.
module mem_arb_watchdog
  import mem_arbiter_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clear_i,
  input  logic run_i,
  output logic expired_o
);

  localparam int CW = wdWidth(TIMEOUT);
  localparam logic [CW-1:0] MAX_COUNT = CW'(TIMEOUT);
  localparam logic [CW-1:0] LAST_COUNT = (TIMEOUT == 0) ? '0 : CW'(TIMEOUT - 1);

  logic [CW-1:0] count_q, count_d;

  // Count saturates at TIMEOUT so it can never wrap back into range
  always_comb begin
    count_d = count_q;
    if (clear_i || !run_i) begin
      count_d = '0;
    end else if (count_q != MAX_COUNT) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired_o = (TIMEOUT != 0) && run_i && !clear_i && (count_q == LAST_COUNT);

endmodule

// File: rtl/mem_arbiter.sv
// Sequences fetch and data requests one at a time onto a single memory bus.
// MEM_ARB_ROUND_ROBIN_EN: alternate grants on collision instead of fixed D priority.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          reset,
  mem_arbiter_if.slave  bus
);

  arbState_e         state_q, state_d;
  arbOwner_e         owner_q, owner_d;
  logic              mStb_q, mStb_d;
  logic              mRw_q, mRw_d;
  logic [ADDR_W-1:0] mAddr_q, mAddr_d;
  logic [DATA_W-1:0] mWdata_q, mWdata_d;
  logic              iAck_q, iAck_d;
  logic              dAck_q, dAck_d;
  logic [DATA_W-1:0] iRdata_q, iRdata_d;
  logic [DATA_W-1:0] dRdata_q, dRdata_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] rdVal;
  logic              anyReq;
  logic              grantD;
  logic              wdExpired;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic lastD_q, lastD_d;
  assign grantD = bus.d_req && (!bus.i_req || !lastD_q);
`else
  assign grantD = bus.d_req;
`endif

  assign anyReq = bus.i_req || bus.d_req;

  mem_arb_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) uWatchdog (
    .clk       (clk),
    .reset     (reset),
    .clear_i   (bus.m_ack),
    .run_i     (state_q == ARB_ST_BUSY),
    .expired_o (wdExpired)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ARB_ST_IDLE;
      owner_q  <= ARB_OWN_D;
      mStb_q   <= 1'b0;
      mRw_q    <= 1'b0;
      mAddr_q  <= '0;
      mWdata_q <= '0;
      iAck_q   <= 1'b0;
      dAck_q   <= 1'b0;
      iRdata_q <= '0;
      dRdata_q <= '0;
      err_q    <= 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      lastD_q  <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      mStb_q   <= mStb_d;
      mRw_q    <= mRw_d;
      mAddr_q  <= mAddr_d;
      mWdata_q <= mWdata_d;
      iAck_q   <= iAck_d;
      dAck_q   <= dAck_d;
      iRdata_q <= iRdata_d;
      dRdata_q <= dRdata_d;
      err_q    <= err_d;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      lastD_q  <= lastD_d;
`endif
    end
  end

  // RESP always returns to IDLE so a held req cannot be issued twice
  always_comb begin
    state_d = state_q;
    case (state_q)
      ARB_ST_IDLE: if (anyReq) state_d = ARB_ST_BUSY;
      ARB_ST_BUSY: if (bus.m_ack || wdExpired) state_d = ARB_ST_RESP;
      ARB_ST_RESP: state_d = ARB_ST_IDLE;
      default:     state_d = ARB_ST_IDLE;
    endcase
  end

  always_comb begin
    owner_d  = owner_q;
    mStb_d   = mStb_q;
    mRw_d    = mRw_q;
    mAddr_d  = mAddr_q;
    mWdata_d = mWdata_q;
    iAck_d   = 1'b0;
    dAck_d   = 1'b0;
    iRdata_d = iRdata_q;
    dRdata_d = dRdata_q;
    err_d    = err_q;
    rdVal    = '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    lastD_d  = lastD_q;
`endif
    case (state_q)
      ARB_ST_IDLE: begin
        mStb_d = 1'b0;
        if (anyReq) begin
          mStb_d = 1'b1;
`ifdef MEM_ARB_ROUND_ROBIN_EN
          lastD_d = grantD;
`endif
          if (grantD) begin
            owner_d  = ARB_OWN_D;
            mRw_d    = bus.d_rw;
            mAddr_d  = bus.d_addr;
            mWdata_d = bus.d_wdata;
          end else begin
            owner_d  = ARB_OWN_I;
            mRw_d    = 1'b0;
            mAddr_d  = bus.i_addr;
            mWdata_d = '0;
          end
        end
      end
      ARB_ST_BUSY: begin
        // A real ack wins over a watchdog expiry landing on the same cycle
        if (bus.m_ack || wdExpired) begin
          mStb_d = 1'b0;
          if (bus.m_ack && !mRw_q) rdVal = bus.m_rdata;
          if (!bus.m_ack) err_d = 1'b1;
          if (owner_q == ARB_OWN_D) begin
            dAck_d   = 1'b1;
            dRdata_d = rdVal;
          end else begin
            iAck_d   = 1'b1;
            iRdata_d = rdVal;
          end
        end
      end
      default: begin
        mStb_d = 1'b0;
      end
    endcase
  end

  assign bus.m_stb   = mStb_q;
  assign bus.m_rw    = mRw_q;
  assign bus.m_addr  = mAddr_q;
  assign bus.m_wdata = mWdata_q;
  assign bus.i_ack   = iAck_q;
  assign bus.d_ack   = dAck_q;
  assign bus.i_rdata = iRdata_q;
  assign bus.d_rdata = dRdata_q;
  assign bus.err     = err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: transaction-level model plus directed scenarios.
// Build with MEM_ARB_ROUND_ROBIN_EN defined to exercise round-robin expectations.
module tb_mem_arbiter;

  localparam int TO = 8;

  logic clk = 1'b0;
  logic reset = 1'b1;

  mem_arbiter_if bus ();

  mem_arbiter #(
    .ADDR_W  (32),
    .DATA_W  (32),
    .TIMEOUT (TO)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial forever #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] memWord(input logic [31:0] addr);
    if (addr == 32'h100) return 32'hDEADBEEF;
    return {addr[15:0], ~addr[15:0]};
  endfunction

  // Memory responder: acks memLatency cycles after the strobe rises (never if <= 0)
  int memLatency = 1;
  int spurReq = 0;
  int spurSeen = 0;
  int stbCycles = 0;

  initial begin
    bus.m_ack = 1'b0;
    bus.m_rdata = '0;
    forever begin
      @(negedge clk);
      bus.m_ack = 1'b0;
      bus.m_rdata = '0;
      if (bus.m_stb) stbCycles++;
      else stbCycles = 0;
      if (spurSeen != spurReq) begin
        spurSeen = spurReq;
        bus.m_ack = 1'b1;
        bus.m_rdata = 32'hBAD0BAD0;
      end else if (bus.m_stb && memLatency > 0 && stbCycles == memLatency) begin
        bus.m_ack = 1'b1;
        bus.m_rdata = memWord(bus.m_addr);
      end
    end
  end

  // Transaction-level model: one outstanding transfer, ack the cycle after it ends
  bit          mActive, mRespond, mStb, mRw, mAckI, mAckD, mErr, mLastD, mOwnD, takeD;
  int          mWaited;
  logic [31:0] mAddr, mWdata, mRdI, mRdD, mWord;
  int          cycle = 0;
  bit          prevStb = 1'b0;
  int          dAckCycles[$];
  int          iAckCycles[$];
  int          stbRise[$];
  int          stbFall[$];
  bit          gRw[$];
  logic [31:0] gAddr[$];
  logic [31:0] gWdata[$];

  initial forever begin
    @(posedge clk);
    if (reset) begin
      mActive = 0; mRespond = 0; mStb = 0; mRw = 0; mAddr = 0; mWdata = 0;
      mAckI = 0; mAckD = 0; mRdI = 0; mRdD = 0; mErr = 0; mLastD = 0; mWaited = 0;
    end else if (mRespond) begin
      mRespond = 0; mAckI = 0; mAckD = 0;
    end else if (mActive) begin
      mWaited++;
      if (bus.m_ack || (TO != 0 && mWaited == TO)) begin
        mWord = (bus.m_ack && !mRw) ? bus.m_rdata : 32'h0;
        if (!bus.m_ack) mErr = 1;
        mActive = 0; mStb = 0; mRespond = 1;
        if (mOwnD) begin mAckD = 1; mRdD = mWord; end
        else begin mAckI = 1; mRdI = mWord; end
      end
    end else if (bus.i_req || bus.d_req) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
      takeD = bus.d_req && (!bus.i_req || !mLastD);
`else
      takeD = bus.d_req;
`endif
      mLastD = takeD; mOwnD = takeD; mActive = 1; mWaited = 0; mStb = 1;
      if (takeD) begin mRw = bus.d_rw; mAddr = bus.d_addr; mWdata = bus.d_wdata; end
      else begin mRw = 0; mAddr = bus.i_addr; mWdata = 0; end
    end
    #1;
    checkOutput("m_stb", 32'(bus.m_stb), 32'(mStb));
    checkOutput("i_ack", 32'(bus.i_ack), 32'(mAckI));
    checkOutput("d_ack", 32'(bus.d_ack), 32'(mAckD));
    checkOutput("err", 32'(bus.err), 32'(mErr));
    checkOutput("m_rw", 32'(bus.m_rw), 32'(mRw));
    checkOutput("m_addr", bus.m_addr, mAddr);
    checkOutput("m_wdata", bus.m_wdata, mWdata);
    if (mAckI) checkOutput("i_rdata", bus.i_rdata, mRdI);
    if (mAckD) checkOutput("d_rdata", bus.d_rdata, mRdD);
    cycle++;
    if (bus.d_ack) dAckCycles.push_back(cycle);
    if (bus.i_ack) iAckCycles.push_back(cycle);
    if (bus.m_stb && !prevStb) begin
      stbRise.push_back(cycle);
      gRw.push_back(bus.m_rw);
      gAddr.push_back(bus.m_addr);
      gWdata.push_back(bus.m_wdata);
    end
    if (!bus.m_stb && prevStb) stbFall.push_back(cycle);
    prevStb = bus.m_stb;
  end

  // Holds one port's request for n back-to-back transfers, advancing address per ack
  task automatic applyStimulus(input bit isD, input int n, input bit rw,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               output logic [31:0] lastRd);
    int done = 0;
    int budget;
    lastRd = 32'hFFFFFFFF;
    @(negedge clk);
    if (isD) begin
      bus.d_req = 1'b1; bus.d_rw = rw; bus.d_addr = addr; bus.d_wdata = wdata;
    end else begin
      bus.i_req = 1'b1; bus.i_addr = addr;
    end
    while (done < n) begin
      budget = 0;
      while (!(isD ? bus.d_ack : bus.i_ack) && budget < 100) begin
        @(negedge clk);
        budget++;
      end
      if (budget >= 100) begin
        checkOutput(isD ? "d_ack_wait" : "i_ack_wait", 32'h0, 32'h1);
        break;
      end
      lastRd = isD ? bus.d_rdata : bus.i_rdata;
      done++;
      if (done < n) begin
        addr = addr + 32'h4;
        wdata = wdata + 32'h1;
        if (isD) begin bus.d_addr = addr; bus.d_wdata = wdata; end
        else bus.i_addr = addr;
      end else begin
        if (isD) bus.d_req = 1'b0;
        else bus.i_req = 1'b0;
      end
      @(negedge clk);
    end
    if (isD) bus.d_req = 1'b0;
    else bus.i_req = 1'b0;
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL global_timeout: simulation did not finish");
    $fatal(1, "[TB] global timeout");
  end

  initial begin
    logic [31:0] rdA, rdB;
    logic [31:0] expAddr[4];
    bit          expRw[4];
    int          g0, a0, i0, waited;

    bus.i_req = 0; bus.i_addr = 0; bus.d_req = 0; bus.d_rw = 0; bus.d_addr = 0; bus.d_wdata = 0;
    repeat (3) @(negedge clk);
    checkOutput("reset_m_stb", 32'(bus.m_stb), 32'h0);
    checkOutput("reset_err", 32'(bus.err), 32'h0);
    checkOutput("reset_i_rdata", bus.i_rdata, 32'h0);
    checkOutput("reset_d_rdata", bus.d_rdata, 32'h0);
    checkOutput("reset_m_addr", bus.m_addr, 32'h0);
    reset = 1'b0;

    $display("[TB] single fetch");
    memLatency = 2;
    a0 = dAckCycles.size();
    @(negedge clk);
    bus.i_req = 1'b1; bus.i_addr = 32'h100;
    @(posedge clk); #1;
    checkOutput("fetch_stb_next_cycle", 32'(bus.m_stb), 32'h1);
    waited = 0;
    @(negedge clk);
    waited++;
    while (!bus.i_ack && waited < 50) begin @(negedge clk); waited++; end
    checkOutput("fetch_latency", 32'(waited), 32'd3);
    checkOutput("fetch_rdata", bus.i_rdata, 32'hDEADBEEF);
    bus.i_req = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("fetch_no_dack", 32'(dAckCycles.size() - a0), 32'h0);

    $display("[TB] collision, one each");
    memLatency = 1;
    g0 = gRw.size();
    fork
      applyStimulus(1'b1, 1, 1'b1, 32'h20, 32'h5, rdA);
      applyStimulus(1'b0, 1, 1'b0, 32'h40, 32'h0, rdB);
    join
    checkOutput("collision_grants", 32'(gRw.size() - g0), 32'd2);
    if (gRw.size() >= g0 + 2) begin
      checkOutput("collision_first_rw", 32'(gRw[g0]), 32'h1);
      checkOutput("collision_first_wdata", gWdata[g0], 32'h5);
      checkOutput("collision_first_addr", gAddr[g0], 32'h20);
      checkOutput("collision_second_addr", gAddr[g0 + 1], 32'h40);
    end
    checkOutput("collision_write_rdata", rdA, 32'h0);
    checkOutput("collision_fetch_rdata", rdB, 32'h0040FFBF);

    $display("[TB] collision, two each");
`ifdef MEM_ARB_ROUND_ROBIN_EN
    expRw = '{1'b1, 1'b0, 1'b1, 1'b0};
    expAddr = '{32'h80, 32'h200, 32'h84, 32'h204};
`else
    expRw = '{1'b1, 1'b1, 1'b0, 1'b0};
    expAddr = '{32'h80, 32'h84, 32'h200, 32'h204};
`endif
    g0 = gRw.size();
    fork
      applyStimulus(1'b1, 2, 1'b1, 32'h80, 32'h7, rdA);
      applyStimulus(1'b0, 2, 1'b0, 32'h200, 32'h0, rdB);
    join
    checkOutput("order_grants", 32'(gRw.size() - g0), 32'd4);
    for (int k = 0; k < 4; k++) begin
      if (gRw.size() > g0 + k) begin
        checkOutput("order_rw", 32'(gRw[g0 + k]), 32'(expRw[k]));
        checkOutput("order_addr", gAddr[g0 + k], expAddr[k]);
      end
    end

    $display("[TB] back-to-back data reads");
    a0 = dAckCycles.size();
    g0 = stbRise.size();
    i0 = stbFall.size();
    applyStimulus(1'b1, 4, 1'b0, 32'h1000, 32'h0, rdA);
    checkOutput("b2b_ack_count", 32'(dAckCycles.size() - a0), 32'd4);
    checkOutput("b2b_last_rdata", rdA, 32'h100CEFF3);
    for (int k = 1; k < 4; k++) begin
      if (dAckCycles.size() > a0 + k)
        checkOutput("b2b_ack_gap_ge3", 32'(dAckCycles[a0 + k] - dAckCycles[a0 + k - 1] >= 3), 32'h1);
      if (stbRise.size() > g0 + k && stbFall.size() > i0 + k - 1)
        checkOutput("b2b_stb_low_ge1", 32'(stbRise[g0 + k] - stbFall[i0 + k - 1] >= 1), 32'h1);
    end

    $display("[TB] watchdog timeout");
    memLatency = -1;
    g0 = stbRise.size();
    i0 = stbFall.size();
    applyStimulus(1'b0, 1, 1'b0, 32'h300, 32'h0, rdA);
    checkOutput("timeout_err", 32'(bus.err), 32'h1);
    checkOutput("timeout_rdata", rdA, 32'h0);
    if (stbRise.size() > g0 && stbFall.size() > i0)
      checkOutput("timeout_stb_cycles", 32'(stbFall[i0] - stbRise[g0]), 32'd8);
    memLatency = 1;
    applyStimulus(1'b1, 1, 1'b0, 32'h44, 32'h0, rdA);
    checkOutput("post_timeout_rdata", rdA, 32'h0044FFBB);
    checkOutput("err_sticky", 32'(bus.err), 32'h1);

    $display("[TB] reset while busy");
    memLatency = -1;
    a0 = dAckCycles.size();
    @(negedge clk);
    bus.d_req = 1'b1; bus.d_rw = 1'b0; bus.d_addr = 32'h500;
    repeat (2) @(negedge clk);
    checkOutput("pre_reset_stb", 32'(bus.m_stb), 32'h1);
    reset = 1'b1;
    bus.d_req = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    spurReq++;
    repeat (3) @(negedge clk);
    checkOutput("post_reset_stb", 32'(bus.m_stb), 32'h0);
    checkOutput("post_reset_err", 32'(bus.err), 32'h0);
    checkOutput("post_reset_addr", bus.m_addr, 32'h0);
    checkOutput("post_reset_d_rdata", bus.d_rdata, 32'h0);
    checkOutput("post_reset_no_ack", 32'(dAckCycles.size() - a0), 32'h0);

    $display("[TB] spurious m_ack in idle");
    a0 = dAckCycles.size();
    i0 = iAckCycles.size();
    spurReq++;
    repeat (3) @(negedge clk);
    checkOutput("spurious_no_ack", 32'(dAckCycles.size() - a0 + iAckCycles.size() - i0), 32'h0);
    checkOutput("spurious_stb", 32'(bus.m_stb), 32'h0);
    memLatency = 1;
    applyStimulus(1'b0, 1, 1'b0, 32'h104, 32'h0, rdA);
    checkOutput("spurious_then_fetch", rdA, 32'h0104FEFB);

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
